// File: rtl/io_event_map_pkg.sv
// Shared definitions for the I/O event bridge: bus region encoding and I/O register offsets.
package io_event_map_pkg;

    typedef enum logic [1:0] {
        REG_RAM  = 2'd0,
        REG_VGA  = 2'd1,
        REG_IO   = 2'd2,
        REG_NONE = 2'd3
    } region_e;

    localparam int OFF_PEND      = 0;
    localparam int OFF_IEN       = 1;
    localparam int OFF_FLAG_BASE = 2;
    localparam int OFF_STRIDE    = 2;

endpackage

// File: rtl/io_event_map_event_chan.sv
// One event input channel: 2-flop synchronizer, rising-edge detect, sticky flag and wrapping counter.
module io_event_map_event_chan #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ev_i,
    input  logic             rd_flag_i,
    input  logic             wr_cnt_i,
    input  logic [CNT_W-1:0] cnt_in_i,
    output logic             flag_o,
    output logic [CNT_W-1:0] count_o
);

    logic             s1_q, s2_q, prev_q;
    logic             flag_q, flag_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rise_w;

    assign rise_w = s2_q & ~prev_q;

    always_comb begin
        flag_d = flag_q;
        cnt_d  = cnt_q;
        // A new edge outranks a same-cycle read clear so no event is lost.
        if (rise_w) begin
            flag_d = 1'b1;
        end else if (rd_flag_i) begin
            flag_d = 1'b0;
        end
        if (wr_cnt_i) begin
            cnt_d = cnt_in_i;
        end else if (rise_w) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            prev_q <= 1'b0;
            flag_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            s1_q   <= ev_i;
            s2_q   <= s1_q;
            prev_q <= s2_q;
            flag_q <= flag_d;
            cnt_q  <= cnt_d;
        end
    end

    assign flag_o  = flag_q;
    assign count_o = cnt_q;

endmodule

// File: rtl/io_event_map.sv
// Memory-mapped bridge from the CPU data port to RAM, the VGA window and the event-channel registers.
module io_event_map
    import io_event_map_pkg::*;
#(
    parameter int              DATA     = 18,
    parameter int              ADDR     = 16,
    parameter int              RAM_ADDR = 14,
    parameter int              NCH      = 4,
    parameter int              CNT_W    = 8,
    parameter logic [ADDR-1:0] IO_BASE  = 16'h00FE,
    parameter logic [3:0]      VGA_TAG  = 4'hF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NCH-1:0]      ev_i,
    input  logic [ADDR-1:0]     addr_i,
    input  logic                wr_i,
    input  logic [DATA-1:0]     din_i,
    output logic [DATA-1:0]     dout_o,
    output logic                ram_we_o,
    output logic [RAM_ADDR-1:0] ram_addr_o,
    input  logic [DATA-1:0]     ram_dout_i,
    output logic                vga_we_o,
    output logic [ADDR-5:0]     vga_addr_o,
    output logic [DATA-1:0]     vga_din_o,
    output logic                irq_o
);

    localparam logic [ADDR-1:0] IO_SPAN = ADDR'(OFF_FLAG_BASE + OFF_STRIDE * NCH);

    region_e          region_w, region_d, region_q;
    logic [ADDR-1:0]  io_off_w;
    logic [NCH-1:0]   flag_w, rd_flag_w, wr_cnt_w;
    logic [CNT_W-1:0] cnt_w [NCH];
    logic [DATA-1:0]  io_rdata_w, dout_d, dout_q;
    logic [NCH-1:0]   ien_d, ien_q;
    logic             vga_we_d, vga_we_q;
    logic [ADDR-5:0]  vga_addr_d, vga_addr_q;
    logic [DATA-1:0]  vga_din_d, vga_din_q;
    logic             irq_d, irq_q;

    for (genvar g = 0; g < NCH; g++) begin : g_chan
        io_event_map_event_chan #(.CNT_W(CNT_W)) u_chan (
            .clk       (clk),
            .rst_n     (rst_n),
            .ev_i      (ev_i[g]),
            .rd_flag_i (rd_flag_w[g]),
            .wr_cnt_i  (wr_cnt_w[g]),
            .cnt_in_i  (din_i[CNT_W-1:0]),
            .flag_o    (flag_w[g]),
            .count_o   (cnt_w[g])
        );
    end

    // Wrapping subtraction makes addresses below IO_BASE fall outside the span.
    assign io_off_w = addr_i - IO_BASE;

    always_comb begin
        if (addr_i[ADDR-1 -: 4] == VGA_TAG) begin
            region_w = REG_VGA;
        end else if (io_off_w < IO_SPAN) begin
            region_w = REG_IO;
        end else if ((addr_i >> RAM_ADDR) == '0) begin
            region_w = REG_RAM;
        end else begin
            region_w = REG_NONE;
        end
    end

    always_comb begin
        rd_flag_w  = '0;
        wr_cnt_w   = '0;
        io_rdata_w = '0;
        ien_d      = ien_q;
        if (region_w == REG_IO) begin
            if (io_off_w == ADDR'(OFF_PEND)) begin
                io_rdata_w = DATA'(flag_w);
            end
            if (io_off_w == ADDR'(OFF_IEN)) begin
                io_rdata_w = DATA'(ien_q);
                if (wr_i) ien_d = din_i[NCH-1:0];
            end
            for (int k = 0; k < NCH; k++) begin
                if (io_off_w == ADDR'(OFF_FLAG_BASE + OFF_STRIDE * k)) begin
                    io_rdata_w   = DATA'(flag_w[k]);
                    rd_flag_w[k] = !wr_i;
                end
                if (io_off_w == ADDR'(OFF_FLAG_BASE + OFF_STRIDE * k + 1)) begin
                    io_rdata_w  = DATA'(cnt_w[k]);
                    wr_cnt_w[k] = wr_i;
                end
            end
        end
    end

    always_comb begin
        dout_d     = (region_w == REG_IO && !wr_i) ? io_rdata_w : '0;
        region_d   = wr_i ? REG_NONE : region_w;
        vga_we_d   = wr_i && (region_w == REG_VGA);
        vga_addr_d = vga_we_d ? addr_i[ADDR-5:0] : vga_addr_q;
        vga_din_d  = vga_we_d ? din_i : vga_din_q;
        irq_d      = |(flag_w & ien_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            region_q   <= REG_NONE;
            dout_q     <= '0;
            ien_q      <= '0;
            vga_we_q   <= 1'b0;
            vga_addr_q <= '0;
            vga_din_q  <= '0;
            irq_q      <= 1'b0;
        end else begin
            region_q   <= region_d;
            dout_q     <= dout_d;
            ien_q      <= ien_d;
            vga_we_q   <= vga_we_d;
            vga_addr_q <= vga_addr_d;
            vga_din_q  <= vga_din_d;
            irq_q      <= irq_d;
        end
    end

    // RAM data arrives a cycle late from the block RAM itself, so only the tag is registered.
    assign dout_o     = (region_q == REG_RAM) ? ram_dout_i : dout_q;
    assign ram_we_o   = wr_i && (region_w == REG_RAM);
    assign ram_addr_o = addr_i[RAM_ADDR-1:0];
    assign vga_we_o   = vga_we_q;
    assign vga_addr_o = vga_addr_q;
    assign vga_din_o  = vga_din_q;
    assign irq_o      = irq_q;

endmodule

// File: tb/tb_io_event_map.sv
// Bench for io_event_map: cycle model of the register map plus directed literal checks.
module tb_io_event_map;

    localparam logic [15:0] PARK = 16'h8000;

    logic        clk, rst_n;
    logic [3:0]  ev_i;
    logic [15:0] addr_i;
    logic        wr_i;
    logic [17:0] din_i;
    logic [17:0] dout_o;
    logic        ram_we_o;
    logic [13:0] ram_addr_o;
    logic [17:0] ram_dout_i;
    logic        vga_we_o;
    logic [11:0] vga_addr_o;
    logic [17:0] vga_din_o;
    logic        irq_o;

    int n_checks = 0;
    int n_fail   = 0;

    io_event_map dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ev_i       (ev_i),
        .addr_i     (addr_i),
        .wr_i       (wr_i),
        .din_i      (din_i),
        .dout_o     (dout_o),
        .ram_we_o   (ram_we_o),
        .ram_addr_o (ram_addr_o),
        .ram_dout_i (ram_dout_i),
        .vga_we_o   (vga_we_o),
        .vga_addr_o (vga_addr_o),
        .vga_din_o  (vga_din_o),
        .irq_o      (irq_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read RAM standing in for the block RAM.
    logic [17:0] mem [16384];
    always @(posedge clk) begin
        ram_dout_i <= mem[ram_addr_o];
        if (ram_we_o) mem[ram_addr_o] <= din_i;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // 0 = RAM, 1 = VGA, 2 = I/O, 3 = unmapped
    function automatic int region_of(input logic [15:0] a);
        if (a[15:12] == 4'hF) return 1;
        if (a >= 16'h00FE && a <= 16'h0107) return 2;
        if (a < 16'h4000) return 0;
        return 3;
    endfunction

    // Model state: what each register must hold after the most recent clock edge.
    logic [3:0]  m_flag = '0, m_ien = '0;
    logic [7:0]  m_cnt [4] = '{default: '0};
    logic [3:0]  ev_h1 = '0, ev_h2 = '0, ev_h3 = '0;
    logic [17:0] m_dout = '0, m_vga_din = '0, rv;
    logic [11:0] m_vga_addr = '0;
    logic        m_dout_valid = 1'b1, m_irq = 1'b0, m_vga_we = 1'b0;
    logic [3:0]  rise;
    int          reg_k, off;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_flag = '0; m_ien = '0;
                for (int k = 0; k < 4; k++) m_cnt[k] = '0;
                ev_h1 = '0; ev_h2 = '0; ev_h3 = '0;
                m_dout = '0; m_dout_valid = 1'b1; m_irq = 1'b0;
                m_vga_we = 1'b0; m_vga_addr = '0; m_vga_din = '0;
            end else begin
                // An input level seen at edge t-2 but not at t-3 is a new event now.
                rise  = ev_h2 & ~ev_h3;
                reg_k = region_of(addr_i);
                off   = int'(addr_i) - 254;
                rv    = '0;
                if (reg_k == 0) rv = mem[addr_i[13:0]];
                else if (reg_k == 2) begin
                    if (off == 0)          rv = {14'b0, m_flag};
                    else if (off == 1)     rv = {14'b0, m_ien};
                    else if (off % 2 == 0) rv = {17'b0, m_flag[(off - 2) / 2]};
                    else                   rv = {10'b0, m_cnt[(off - 3) / 2]};
                end
                m_dout_valid = !wr_i;
                m_dout       = rv;
                m_irq        = |(m_flag & m_ien);
                m_vga_we     = wr_i && reg_k == 1;
                if (m_vga_we) begin
                    m_vga_addr = addr_i[11:0];
                    m_vga_din  = din_i;
                end
                for (int k = 0; k < 4; k++) begin
                    if (rise[k]) m_flag[k] = 1'b1;
                    else if (!wr_i && reg_k == 2 && off == 2 + 2 * k) m_flag[k] = 1'b0;
                    if (wr_i && reg_k == 2 && off == 3 + 2 * k) m_cnt[k] = din_i[7:0];
                    else if (rise[k]) m_cnt[k] = m_cnt[k] + 8'd1;
                end
                if (wr_i && reg_k == 2 && off == 1) m_ien = din_i[3:0];
                ev_h3 = ev_h2; ev_h2 = ev_h1; ev_h1 = ev_i;
            end
        end
    end

    always @(negedge clk) begin
        #2;
        if (m_dout_valid) chk("dout", dout_o, m_dout);
        chk("irq", irq_o, m_irq);
        chk("vga_we", vga_we_o, m_vga_we);
        chk("vga_addr", vga_addr_o, m_vga_addr);
        chk("vga_din", vga_din_o, m_vga_din);
        chk("ram_we", ram_we_o, wr_i && region_of(addr_i) == 0);
        chk("ram_addr", ram_addr_o, addr_i[13:0]);
    end

    task automatic cyc(input logic [15:0] a, input logic w, input logic [17:0] d);
        @(negedge clk);
        addr_i = a; wr_i = w; din_i = d;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(PARK, 1'b0, '0);
    endtask

    task automatic rd_lit(input logic [15:0] a, input logic [17:0] exp, input string name);
        cyc(a, 1'b0, '0);
        cyc(PARK, 1'b0, '0);
        #2 chk(name, dout_o, exp);
    endtask

    task automatic pulse(input int ch);
        @(negedge clk); ev_i[ch] = 1'b1; addr_i = PARK; wr_i = 1'b0;
        @(negedge clk); ev_i[ch] = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        mem[16'h0010] = 18'h1234;
        ev_i = '0; addr_i = PARK; wr_i = 1'b0; din_i = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        chk("rst_dout", dout_o, 0);
        chk("rst_irq", irq_o, 0);
        chk("rst_vga_we", vga_we_o, 0);
        @(negedge clk) rst_n = 1'b1;
        idle(2);

        // three events on channel 1, then counter and clear-on-read flag
        repeat (3) pulse(1);
        idle(4);
        rd_lit(16'h0103, 18'd3, "cnt1");
        rd_lit(16'h0102, 18'd1, "flag1");
        rd_lit(16'h0102, 18'd0, "flag1_clr");
        rd_lit(16'h00FE, 18'd0, "pend_clr");

        // counter wrap
        cyc(16'h0101, 1'b1, 18'h0FF);
        pulse(0);
        idle(4);
        rd_lit(16'h0101, 18'd0, "cnt0_wrap");
        rd_lit(16'h0100, 18'd1, "flag0");

        // CNT write in the edge cycle wins; flag still set
        @(negedge clk); ev_i[2] = 1'b1; addr_i = PARK; wr_i = 1'b0;
        @(negedge clk); ev_i[2] = 1'b0;
        @(negedge clk); addr_i = 16'h0105; wr_i = 1'b1; din_i = 18'h010;
        idle(3);
        rd_lit(16'h0105, 18'h010, "cnt2_collide");
        rd_lit(16'h0104, 18'd1, "flag2_collide");

        // FLAG read in the edge cycle returns old value, flag survives
        @(negedge clk); ev_i[3] = 1'b1; addr_i = PARK; wr_i = 1'b0;
        @(negedge clk); ev_i[3] = 1'b0;
        @(negedge clk); addr_i = 16'h0106;
        cyc(PARK, 1'b0, '0);
        #2 chk("flag3_rd_old", dout_o, 0);
        rd_lit(16'h0106, 18'd1, "flag3_kept");

        // interrupt masking and timing
        cyc(16'h00FF, 1'b1, 18'h4);
        pulse(0);
        idle(4);
        #2 chk("irq_masked", irq_o, 0);
        rd_lit(16'h00FF, 18'h4, "ien_rd");
        @(negedge clk); ev_i[2] = 1'b1; addr_i = PARK; wr_i = 1'b0;
        @(negedge clk); ev_i[2] = 1'b0;
        #2 chk("irq_n1", irq_o, 0);
        @(negedge clk); #2 chk("irq_n2", irq_o, 0);
        @(negedge clk); #2 chk("irq_n3", irq_o, 0);
        @(negedge clk); #2 chk("irq_n4", irq_o, 1);
        rd_lit(16'h00FE, 18'h5, "pend_two");
        rd_lit(16'h0104, 18'd1, "flag2_irq");
        chk("irq_hold", irq_o, 1);
        @(negedge clk); #2 chk("irq_drop", irq_o, 0);
        pulse(2);
        idle(3);
        #2 chk("irq_again", irq_o, 1);
        cyc(16'h00FF, 1'b1, 18'h0);
        idle(2);
        #2 chk("irq_ien_mask", irq_o, 0);
        rd_lit(16'h0100, 18'd1, "flag0_clr");
        rd_lit(16'h0104, 18'd1, "flag2_clr");

        // decode: VGA window and RAM write
        cyc(16'hF123, 1'b1, 18'h2A5);
        #2 chk("vga_no_ram_we", ram_we_o, 0);
        idle(1);
        #2 chk("vga_we_lit", vga_we_o, 1);
        chk("vga_addr_lit", vga_addr_o, 12'h123);
        chk("vga_din_lit", vga_din_o, 18'h2A5);
        idle(1);
        #2 chk("vga_we_once", vga_we_o, 0);
        rd_lit(16'hF123, 18'd0, "vga_rd");
        cyc(16'h0020, 1'b1, 18'h155);
        #2 chk("ram_we_lit", ram_we_o, 1);
        idle(1);
        rd_lit(16'h0020, 18'h155, "ram_rdback");

        // back-to-back reads across regions
        cyc(16'h00FF, 1'b1, 18'hF);
        pulse(3);
        idle(4);
        @(negedge clk); addr_i = 16'h0010; wr_i = 1'b0;
        @(negedge clk); addr_i = 16'h00FE;
        #2 chk("lat_ram0", dout_o, 18'h1234);
        @(negedge clk); addr_i = 16'h0010;
        #2 chk("lat_pend", dout_o, 18'h8);
        @(negedge clk); addr_i = PARK;
        #2 chk("lat_ram1", dout_o, 18'h1234);
        @(negedge clk);
        #2 chk("unmapped_rd", dout_o, 0);

        // reset in the middle of a VGA write with events toggling
        cyc(16'hF456, 1'b1, 18'h3);
        ev_i = 4'b0101;
        @(posedge clk);
        #3 chk("pre_rst_vga_we", vga_we_o, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_vga_we", vga_we_o, 0);
        chk("mid_rst_vga_addr", vga_addr_o, 0);
        chk("mid_rst_vga_din", vga_din_o, 0);
        chk("mid_rst_irq", irq_o, 0);
        chk("mid_rst_dout", dout_o, 0);
        repeat (3) begin
            @(negedge clk); ev_i = ~ev_i; addr_i = PARK; wr_i = 1'b0;
        end
        @(negedge clk); ev_i = '0; rst_n = 1'b1;
        idle(4);
        rd_lit(16'h00FE, 18'd0, "post_rst_pend");
        rd_lit(16'h0101, 18'd0, "post_rst_cnt0");
        rd_lit(16'h0103, 18'd0, "post_rst_cnt1");
        rd_lit(16'h0105, 18'd0, "post_rst_cnt2");
        rd_lit(16'h0107, 18'd0, "post_rst_cnt3");
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
